// File: rtl/lf_sample_queue_if.sv
// Stereo sample stream into the FIR burst queue, plus the burst stream and overrun flag back out.
interface lf_sample_queue_if #(
    parameter int DW = 16
);
    logic          wrt_smpl;
    logic [DW-1:0] lft_smpl;
    logic [DW-1:0] rght_smpl;
    logic          sequencing;
    logic [DW-1:0] lft_out;
    logic [DW-1:0] rght_out;
    logic          ovr;

    modport master (
        output wrt_smpl, lft_smpl, rght_smpl,
        input  sequencing, lft_out, rght_out, ovr
    );

    modport slave (
        input  wrt_smpl, lft_smpl, rght_smpl,
        output sequencing, lft_out, rght_out, ovr
    );
endinterface

// File: rtl/lf_sample_queue.sv
// Circular stereo sample queue that streams the newest TAPS samples to the FIR on every accepted sample.
// Optional macro DECIM_EN: accept only every other wrt_smpl strobe (1st, 3rd, 5th ... after reset).
module lf_sample_queue #(
    parameter int DW    = 16,
    parameter int DEPTH = 1536,
    parameter int TAPS  = 1021
) (
    input logic              clk,
    input logic              rst,
    lf_sample_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   BACK    = (AW + 1)'(DEPTH - TAPS);
    localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
    localparam logic [CW-1:0] TAPS_M1 = CW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, GAP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   new_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_next;
    logic [AW-1:0]   rd_next;
    logic [AW-1:0]   base;
    logic [AW:0]     sum;
    logic [AW-1:0]   burst_start;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   out_cnt;
    logic            pend;
    logic            ovr_q;
    logic            accept;
    logic            request;
    logic            start_burst;
    logic            rd_en;
    logic [DW-1:0]   lft_q;
    logic [DW-1:0]   rght_q;
    logic [2*DW-1:0] mem [DEPTH];

`ifdef DECIM_EN
    logic phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
        end else if (bus.wrt_smpl) begin
            phase <= ~phase;
        end
    end

    assign accept = bus.wrt_smpl & ~phase;
`else
    assign accept = bus.wrt_smpl;
`endif

    assign request = accept && (cnt >= TAPS_M1);

    // A burst begins TAPS entries behind the write pointer as it stands after this cycle's write.
    always_comb begin
        wr_next     = (new_ptr == LAST) ? '0 : new_ptr + 1'b1;
        rd_next     = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        base        = accept ? wr_next : new_ptr;
        sum         = {1'b0, base} + BACK;
        burst_start = (sum >= DEPTH_W) ? AW'(sum - DEPTH_W) : AW'(sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_burst = 1'b0;
        rd_en       = 1'b0;
        case (state)
            IDLE: begin
                if (request || pend) begin
                    start_burst = 1'b1;
                    state_nxt   = PRIME;
                end
            end
            PRIME: begin
                rd_en     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (out_cnt == TAPS_C) begin
                    state_nxt = GAP;
                end else begin
                    rd_en = 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The RAM is never reset; only pointers and counts decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[new_ptr] <= {bus.lft_smpl, bus.rght_smpl};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_ptr <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            out_cnt <= '0;
            pend    <= 1'b0;
            ovr_q   <= 1'b0;
            lft_q   <= '0;
            rght_q  <= '0;
        end else begin
            if (accept) begin
                new_ptr <= wr_next;
                if (cnt != TAPS_C) begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (start_burst) begin
                rd_ptr <= burst_start;
            end else if (rd_en) begin
                rd_ptr <= rd_next;
            end

            if (state == PRIME) begin
                out_cnt <= CW'(1);
            end else if (rd_en) begin
                out_cnt <= out_cnt + 1'b1;
            end

            // At most one burst may be owed beyond the running one; further requests are lost.
            if (start_burst) begin
                pend <= 1'b0;
            end else if (request && (state != IDLE)) begin
                if (pend) begin
                    ovr_q <= 1'b1;
                end else begin
                    pend <= 1'b1;
                end
            end

            if (rd_en) begin
                {lft_q, rght_q} <= mem[rd_ptr];
            end
        end
    end

    assign bus.sequencing = (state == STREAM);
    assign bus.lft_out    = lft_q;
    assign bus.rght_out   = rght_q;
    assign bus.ovr        = ovr_q;
endmodule

// File: tb/tb_lf_sample_queue.sv
// Randomised scoreboard bench for lf_sample_queue: a transaction-level model predicts each burst sample and its cycle.
module tb_lf_sample_queue;
    localparam int DW    = 16;
    localparam int DEPTH = 24;
    localparam int TAPS  = 8;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    lf_sample_queue_if #(.DW(DW)) bus ();

    lf_sample_queue #(
        .DW(DW),
        .DEPTH(DEPTH),
        .TAPS(TAPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t            exp_q[$];
    logic [2*DW-1:0] hist[$];
    int              checks   = 0;
    int              errors   = 0;
    int              edge_cnt = 0;
    int              accepted = 0;
    int              busy_end = 0;
    int              rst_edge = -1;
    bit              pend_m   = 1'b0;
    bit              ovr_m    = 1'b0;
    bit              phase_m  = 1'b0;
    bit              mon_on   = 1'b0;
    logic [DW-1:0]   held_l;
    logic [DW-1:0]   held_r;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    // Drives one strobe starting at the current negedge, then idles gap-1 cycles.
    task automatic apply_stimulus(input logic [DW-1:0] l, input logic [DW-1:0] r, input int gap);
        bus.wrt_smpl  = 1'b1;
        bus.lft_smpl  = l;
        bus.rght_smpl = r;
        @(negedge clk);
        bus.wrt_smpl = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Reference model: one burst may run and one may be owed; a burst streams the newest TAPS samples at its start.
    initial begin
        forever begin : model_step
            bit   acc;
            bit   req;
            exp_t x;
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                exp_q.delete();
                accepted = 0;
                pend_m   = 1'b0;
                ovr_m    = 1'b0;
                phase_m  = 1'b0;
                busy_end = 0;
                rst_edge = edge_cnt;
                mon_on   = 1'b1;
            end else begin
                acc = bus.wrt_smpl;
`ifdef DECIM_EN
                acc = bus.wrt_smpl && !phase_m;
                if (bus.wrt_smpl) phase_m = !phase_m;
`endif
                req = 1'b0;
                if (acc) begin
                    hist.push_back({bus.lft_smpl, bus.rght_smpl});
                    if (hist.size() > 64) void'(hist.pop_front());
                    if (accepted < TAPS) accepted++;
                    req = (accepted == TAPS);
                end
                if (edge_cnt >= busy_end && (req || pend_m)) begin
                    for (int k = TAPS; k >= 1; k--) begin
                        x.l   = hist[hist.size() - k][2*DW-1:DW];
                        x.r   = hist[hist.size() - k][DW-1:0];
                        x.cyc = edge_cnt + 1 + (TAPS - k);
                        exp_q.push_back(x);
                    end
                    busy_end = edge_cnt + TAPS + 3;
                    pend_m   = 1'b0;
                end else if (req) begin
                    if (pend_m) ovr_m = 1'b1;
                    else        pend_m = 1'b1;
                end
            end
        end
    end

    // Monitor: consumes one expected sample per sequencing cycle, otherwise checks the outputs hold.
    initial begin
        forever begin : monitor_step
            exp_t x;
            @(negedge clk);
            if (mon_on) begin
                if (rst_edge == edge_cnt) begin
                    held_l = '0;
                    held_r = '0;
                end
                if (bus.sequencing === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_sequencing", 32'(bus.sequencing), 32'd0);
                    end else begin
                        x = exp_q.pop_front();
                        check_output("burst_cycle", edge_cnt, x.cyc);
                        check_output("burst_data", {bus.lft_out, bus.rght_out}, {x.l, x.r});
                        held_l = x.l;
                        held_r = x.r;
                    end
                end else begin
                    while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
                        x = exp_q.pop_front();
                        check_output("missed_burst_sample", 32'(bus.sequencing), 32'd1);
                    end
                    check_output("hold_value", {bus.lft_out, bus.rght_out}, {held_l, held_r});
                end
                check_output("ovr", 32'(bus.ovr), 32'(ovr_m));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.wrt_smpl  = 1'b0;
        bus.lft_smpl  = '0;
        bus.rght_smpl = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_output("reset_sequencing", 32'(bus.sequencing), 32'd0);
        check_output("reset_lft_out", 32'(bus.lft_out), 32'd0);
        check_output("reset_rght_out", 32'(bus.rght_out), 32'd0);
        check_output("reset_ovr", 32'(bus.ovr), 32'd0);

`ifdef DECIM_EN
        $display("[TB] decimated intake: 16 strobes");
        for (int v = 1; v <= 16; v++) apply_stimulus(DW'(v), DW'(v + 1000), 20);
        check_output("decim_ovr", 32'(bus.ovr), 32'd0);
`else
        $display("[TB] fill below TAPS, then first burst");
        for (int v = 1; v <= 7; v++) apply_stimulus(DW'(v), DW'(v + 1000), 20);
        check_output("partial_fill_ovr", 32'(bus.ovr), 32'd0);
        apply_stimulus(DW'(8), DW'(1008), 20);

        $display("[TB] 100 spaced random samples");
        for (int i = 0; i < 100; i++) apply_stimulus(DW'($urandom), DW'($urandom), 20);

        $display("[TB] three back-to-back strobes");
        for (int i = 0; i < 3; i++) apply_stimulus(DW'($urandom), DW'($urandom), 1);
        repeat (40) @(negedge clk);
        check_output("overrun_sticky", 32'(bus.ovr), 32'd1);

        $display("[TB] reset in the 4th streaming cycle");
        apply_stimulus(DW'($urandom), DW'($urandom), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_sequencing", 32'(bus.sequencing), 32'd0);
        check_output("abort_ovr_cleared", 32'(bus.ovr), 32'd0);
        for (int i = 0; i < 8; i++) apply_stimulus(DW'($urandom), DW'($urandom), 20);
`endif

        $display("[TB] random strobe spacing");
        for (int i = 0; i < 200; i++) apply_stimulus(DW'($urandom), DW'($urandom), int'($urandom_range(1, 14)));

        repeat (4 * TAPS + 20) @(negedge clk);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
